// File: rtl/uart_frame_loader.sv
// Purpose: parses UART bytes (sync, W, H, W*H pixels, XOR checksum) into frame-buffer writes and a ready/ack frame handoff.
// Latency: registered outputs; mem_we, frame_ready and frame_err appear one clock after the byte strobe that causes them.
// Backpressure: none toward the UART; bytes arriving while a frame is held are dropped and flagged in overrun.
module uart_frame_loader #(
   parameter logic [7:0] SYNC_BYTE   = 8'hAA,
   parameter int         MAX_W       = 320,
   parameter int         MAX_H       = 240,
   parameter int         ADDR_W      = 17,
   parameter int         TIMEOUT_CYC = 25000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic [15:0]       frame_w,
   output logic [15:0]       frame_h,
   output logic              frame_ready,
   input  logic              frame_ack,
   output logic              frame_err,
   output logic [1:0]        err_code,
   output logic              overrun,
   output logic              busy
);
   localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int TOT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [TOT_W-1:0] PIX_ONE = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_DIMS    = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;
   localparam logic [1:0] ERR_CSUM    = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE, S_W_LO, S_W_HI, S_H_LO, S_H_HI, S_PIXELS, S_CSUM, S_READY
   } state_t;

   state_t           state, nxt_state;
   logic [15:0]      width_q;
   logic [7:0]       h_lo_q;
   logic [7:0]       csum;
   logic [TOT_W-1:0] pix_cnt;
   logic [TOT_W-1:0] total;
   logic [CNT_W-1:0] idle_cnt;

   logic [15:0]      height_in;
   logic [TOT_W-1:0] dim_prod;
   logic             in_frame;
   logic             dims_bad;
   logic             last_pix;
   logic             csum_ok;
   logic             timeout_hit;
   logic             pix_wr;
   logic             sync_acc;
   logic             err_now;
   logic [1:0]       err_val;

   // Height is only complete on the H_HI byte itself, so it is assembled from the live rx_data.
   assign height_in   = {rx_data, h_lo_q};
   assign dim_prod    = TOT_W'({16'd0, width_q} * {16'd0, height_in});
   assign dims_bad    = (width_q == 16'd0) || (height_in == 16'd0) ||
                        (width_q > 16'(MAX_W)) || (height_in > 16'(MAX_H));
   assign last_pix    = (pix_cnt + PIX_ONE) == total;
   assign csum_ok     = (rx_data == csum);
   assign in_frame    = (state != S_IDLE) && (state != S_READY);
   // A byte on the terminal idle cycle wins over the timeout.
   assign timeout_hit = in_frame && !rx_valid && (idle_cnt == TO_LAST);

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= nxt_state;
   end

   // Next-state decode: byte-driven advance, plus timeout and ack exits.
   always_comb begin
      nxt_state = state;
      case (state)
         S_IDLE:   if (rx_valid && (rx_data == SYNC_BYTE)) nxt_state = S_W_LO;
         S_W_LO:   if (rx_valid) nxt_state = S_W_HI;
         S_W_HI:   if (rx_valid) nxt_state = S_H_LO;
         S_H_LO:   if (rx_valid) nxt_state = S_H_HI;
         S_H_HI:   if (rx_valid) nxt_state = dims_bad ? S_IDLE : S_PIXELS;
         S_PIXELS: if (rx_valid && last_pix) nxt_state = S_CSUM;
         S_CSUM:   if (rx_valid) nxt_state = csum_ok ? S_READY : S_IDLE;
         S_READY:  if (frame_ack) nxt_state = S_IDLE;
         default:  nxt_state = S_IDLE;
      endcase
      if (timeout_hit) nxt_state = S_IDLE;
   end

   // Output decode: pixel write strobe, sync acceptance and error classification for this cycle.
   always_comb begin
      pix_wr   = 1'b0;
      sync_acc = 1'b0;
      err_now  = 1'b0;
      err_val  = ERR_NONE;
      case (state)
         S_IDLE:   sync_acc = rx_valid && (rx_data == SYNC_BYTE);
         S_H_HI:   if (rx_valid && dims_bad) begin
                      err_now = 1'b1;
                      err_val = ERR_DIMS;
                   end
         S_PIXELS: pix_wr = rx_valid;
         S_CSUM:   if (rx_valid && !csum_ok) begin
                      err_now = 1'b1;
                      err_val = ERR_CSUM;
                   end
         default:  ;
      endcase
      if (timeout_hit) begin
         err_now = 1'b1;
         err_val = ERR_TIMEOUT;
      end
   end

   // Frame parsing datapath: header capture, checksum, pixel counter, idle timer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         width_q  <= '0;
         h_lo_q   <= '0;
         csum     <= '0;
         pix_cnt  <= '0;
         total    <= '0;
         idle_cnt <= '0;
      end else begin
         if (sync_acc)
            csum <= '0;
         else if (rx_valid && in_frame && (state != S_CSUM))
            csum <= csum ^ rx_data;
         if (sync_acc)    pix_cnt <= '0;
         else if (pix_wr) pix_cnt <= pix_cnt + PIX_ONE;
         if (rx_valid && (state == S_W_LO)) width_q[7:0]  <= rx_data;
         if (rx_valid && (state == S_W_HI)) width_q[15:8] <= rx_data;
         if (rx_valid && (state == S_H_LO)) h_lo_q        <= rx_data;
         if (rx_valid && (state == S_H_HI) && !dims_bad) total <= dim_prod;
         if (rx_valid || !in_frame || timeout_hit) idle_cnt <= '0;
         else                                      idle_cnt <= idle_cnt + 1'b1;
      end
   end

   // Registered outputs: memory write port, frame status and error reporting.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         frame_w     <= '0;
         frame_h     <= '0;
         frame_ready <= 1'b0;
         frame_err   <= 1'b0;
         err_code    <= ERR_NONE;
         overrun     <= 1'b0;
         busy        <= 1'b0;
      end else begin
         mem_we <= pix_wr;
         if (pix_wr) begin
            mem_addr  <= pix_cnt[ADDR_W-1:0];
            mem_wdata <= rx_data;
         end
         if (rx_valid && (state == S_H_HI) && !dims_bad) begin
            frame_w <= width_q;
            frame_h <= height_in;
         end
         frame_ready <= (nxt_state == S_READY);
         busy        <= (nxt_state != S_IDLE) && (nxt_state != S_READY);
         frame_err   <= err_now;
         if (sync_acc)     err_code <= ERR_NONE;
         else if (err_now) err_code <= err_val;
         // Ack releases the frame and clears the overrun flag even if a byte lands in the same cycle.
         if (state == S_READY) begin
            if (frame_ack)     overrun <= 1'b0;
            else if (rx_valid) overrun <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_uart_frame_loader.sv
// Purpose: randomized and directed frames for uart_frame_loader checked against a frame-level reference parser.
// Latency: outputs sampled 1 time unit after the clock edge; writes captured on the falling edge.
// Backpressure: byte strobes always at least 2 cycles apart; overrun exercised by bytes sent while a frame is held.
module tb_uart_frame_loader;
   localparam int TO = 40;
   typedef logic [7:0] byte_q_t [$];

   logic        clk = 1'b0;
   logic        reset_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        mem_we;
   logic [16:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [15:0] frame_w;
   logic [15:0] frame_h;
   logic        frame_ready;
   logic        frame_ack;
   logic        frame_err;
   logic [1:0]  err_code;
   logic        overrun;
   logic        busy;

   uart_frame_loader #(.TIMEOUT_CYC(TO)) dut (
      .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .frame_w(frame_w), .frame_h(frame_h), .frame_ready(frame_ready),
      .frame_ack(frame_ack), .frame_err(frame_err), .err_code(err_code),
      .overrun(overrun), .busy(busy)
   );

   always #5 clk = ~clk;

   // Write and error-pulse capture; mem_we must follow a byte strobe by exactly one cycle.
   logic [16:0] wr_addr [$];
   logic [7:0]  wr_data [$];
   int          err_pulses = 0;
   int          bad_timing = 0;
   logic        strobe_d = 1'b0;

   always @(posedge clk) strobe_d <= rx_valid;

   always @(negedge clk) begin
      if (mem_we) begin
         wr_addr.push_back(mem_addr);
         wr_data.push_back(mem_wdata);
         if (!strobe_d) bad_timing <= bad_timing + 1;
      end
      if (frame_err) err_pulses <= err_pulses + 1;
   end

   int n_vec = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: parse one framed byte list into expected writes and outcome.
   logic [16:0] exp_wa [$];
   logic [7:0]  exp_wd [$];
   logic [1:0]  exp_err;
   logic        exp_ready;
   logic [15:0] exp_fw = 16'd0;
   logic [15:0] exp_fh = 16'd0;

   task automatic model_frame(input byte_q_t b);
      int i, w, h, n;
      logic [7:0] x;
      exp_wa.delete();
      exp_wd.delete();
      exp_err   = 2'd0;
      exp_ready = 1'b0;
      i = 0;
      while (i < b.size() && b[i] != 8'hAA) i++;
      w = int'(b[i+1]) + 256 * int'(b[i+2]);
      h = int'(b[i+3]) + 256 * int'(b[i+4]);
      x = b[i+1] ^ b[i+2] ^ b[i+3] ^ b[i+4];
      if (w == 0 || h == 0 || w > 320 || h > 240) begin
         exp_err = 2'd1;
         return;
      end
      exp_fw = w[15:0];
      exp_fh = h[15:0];
      n = w * h;
      for (int k = 0; k < n; k++) begin
         exp_wa.push_back(k[16:0]);
         exp_wd.push_back(b[i+5+k]);
         x = x ^ b[i+5+k];
      end
      if (b[i+5+n] == x) exp_ready = 1'b1;
      else               exp_err   = 2'd3;
   endtask

   // One byte strobe followed by 'idle' quiet cycles; returns 1 time unit after an edge.
   task automatic send_byte(input logic [7:0] d, input int idle);
      @(posedge clk); #1;
      rx_data  = d;
      rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      repeat (idle - 1) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic run_frame(input byte_q_t b);
      int wbase, ebase;
      wbase = wr_addr.size();
      ebase = err_pulses;
      model_frame(b);
      foreach (b[k]) send_byte(b[k], $urandom_range(1, 3));
      repeat (2) begin
         @(posedge clk); #1;
      end
      check_val("wr_count", wr_addr.size() - wbase, exp_wa.size());
      for (int k = 0; k < exp_wa.size() && wbase + k < wr_addr.size(); k++) begin
         check_val("wr_addr", wr_addr[wbase+k], exp_wa[k]);
         check_val("wr_data", wr_data[wbase+k], exp_wd[k]);
      end
      check_val("frame_ready", frame_ready, exp_ready);
      check_val("err_code", err_code, exp_err);
      check_val("err_pulses", err_pulses - ebase, (exp_err != 2'd0) ? 1 : 0);
      check_val("busy_idle", busy, 0);
      check_val("frame_w", frame_w, exp_fw);
      check_val("frame_h", frame_h, exp_fh);
   endtask

   task automatic do_ack(input bit with_overrun);
      int wbase;
      wbase = wr_addr.size();
      if (with_overrun) begin
         send_byte(8'($urandom), 1);
         check_val("overrun_set", overrun, 1);
         check_val("ready_hold", frame_ready, 1);
         check_val("overrun_nowr", wr_addr.size() - wbase, 0);
      end
      @(posedge clk); #1;
      frame_ack = 1'b1;
      @(posedge clk); #1;
      frame_ack = 1'b0;
      check_val("ready_fall", frame_ready, 0);
      check_val("overrun_clr", overrun, 0);
   endtask

   task automatic gen_frame(input int kind, output byte_q_t q);
      int w, h;
      logic [7:0] x, p;
      q.delete();
      if ($urandom_range(0, 1) == 1) q.push_back(8'($urandom_range(0, 127)));
      q.push_back(8'hAA);
      if (kind == 3) begin
         w = $urandom_range(1, 4);
         h = $urandom_range(1, 4);
         case ($urandom_range(0, 3))
            0: w = 0;
            1: h = 0;
            2: w = $urandom_range(321, 400);
            default: h = $urandom_range(241, 300);
         endcase
      end else begin
         w = $urandom_range(1, 4);
         h = $urandom_range(1, 4);
      end
      q.push_back(w[7:0]);
      q.push_back(w[15:8]);
      q.push_back(h[7:0]);
      q.push_back(h[15:8]);
      if (kind == 3) return;
      x = w[7:0] ^ w[15:8] ^ h[7:0] ^ h[15:8];
      for (int k = 0; k < w * h; k++) begin
         p = 8'($urandom);
         q.push_back(p);
         x = x ^ p;
      end
      if (kind == 2) x = x ^ 8'(1 << $urandom_range(0, 7));
      q.push_back(x);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      byte_q_t q;
      int ebase, kind;
      rx_valid  = 1'b0;
      rx_data   = 8'h00;
      frame_ack = 1'b0;
      reset_n   = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      check_val("rst_mem_we", mem_we, 0);
      check_val("rst_mem_addr", mem_addr, 0);
      check_val("rst_ready", frame_ready, 0);
      check_val("rst_err_code", err_code, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_frame_w", frame_w, 0);
      reset_n = 1'b1;

      // Reference 2x2 frame, then overrun and ack.
      q = '{8'hAA, 8'h02, 8'h00, 8'h02, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h40};
      run_frame(q);
      do_ack(1'b1);

      // Checksum error.
      q = '{8'hAA, 8'h02, 8'h00, 8'h02, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h41};
      run_frame(q);

      // Width 321: rejected; stray byte ignored; then a valid frame.
      q = '{8'hAA, 8'h41, 8'h01, 8'h10, 8'h00};
      run_frame(q);
      send_byte(8'h55, 2);
      check_val("stray_busy", busy, 0);
      check_val("stray_err_code", err_code, 1);
      gen_frame(0, q);
      run_frame(q);
      if (frame_ready) do_ack(1'b0);

      // Timeout: a byte on the last allowed idle cycle is accepted, then silence expires.
      ebase = err_pulses;
      send_byte(8'hAA, 1);
      send_byte(8'h02, 1);
      send_byte(8'h00, TO - 1);
      send_byte(8'h03, 1);
      check_val("to_edge_busy", busy, 1);
      check_val("to_edge_err", err_pulses - ebase, 0);
      repeat (TO + 5) begin
         @(posedge clk); #1;
      end
      check_val("to_err_code", err_code, 2);
      check_val("to_busy", busy, 0);
      check_val("to_pulses", err_pulses - ebase, 1);

      // Randomized frames: valid, checksum error, bad dimensions.
      for (int it = 0; it < 12; it++) begin
         kind = $urandom_range(0, 3);
         gen_frame(kind, q);
         run_frame(q);
         if (frame_ready) do_ack(1'($urandom_range(0, 1)));
      end

      // Reset mid-frame right after the second pixel.
      q = '{8'hAA, 8'h02, 8'h00, 8'h02, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h40};
      for (int k = 0; k < 7; k++) send_byte(q[k], 1);
      reset_n = 1'b0;
      #1;
      check_val("mid_rst_we", mem_we, 0);
      check_val("mid_rst_addr", mem_addr, 0);
      check_val("mid_rst_wdata", mem_wdata, 0);
      check_val("mid_rst_busy", busy, 0);
      check_val("mid_rst_fw", frame_w, 0);
      check_val("mid_rst_fh", frame_h, 0);
      check_val("mid_rst_misc", {frame_ready, frame_err, err_code, overrun}, 0);
      repeat (2) begin
         @(posedge clk); #1;
      end
      reset_n = 1'b1;
      exp_fw  = 16'd0;
      exp_fh  = 16'd0;
      run_frame(q);
      do_ack(1'b0);

      check_val("we_timing", bad_timing, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
